// File: rtl/symbol_sequencer.sv
// Transmit symbol scheduler: frames requester bytes as STP/payload/END, fills idle
// time with IDL, nullifies gapped packets with EDB and inserts SKP ordered sets between packets.
module symbol_sequencer #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_CNT_W    = 16,
  parameter int NUM_SKP      = 3
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       req_valid,
  input  logic [7:0] req_data,
  input  logic       req_last,
  output logic       req_ready,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic       err_abort,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] SYM_STP = 8'hfb;
  localparam logic [7:0] SYM_END = 8'hfd;
  localparam logic [7:0] SYM_EDB = 8'hfe;
  localparam logic [7:0] SYM_SKP = 8'h1c;
  localparam logic [7:0] SYM_IDL = 8'h7c;
  localparam logic [7:0] SYM_COM = 8'hbc;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STP  = 3'd1,
    S_DATA = 3'd2,
    S_LAST = 3'd3,
    S_ENDS = 3'd4,
    S_ABRT = 3'd5,
    S_SKPC = 3'd6,
    S_SKPS = 3'd7
  } state_t;

  state_t               state, next_state;
  logic [1:0]           skp_idx, next_skp_idx;
  logic [SKP_CNT_W-1:0] skp_cnt;
  logic                 skp_pend;
  logic                 skp_wrap;
  state_t               exit_state;
  logic [7:0]           next_data;
  logic                 next_valid;
  logic                 next_err;

  // Handshake: a byte transfers on a posedge where req_valid && req_ready are both
  // high; req_ready depends only on state, so the requester never sees a comb loop.
  assign req_ready = (state == S_STP) || (state == S_DATA);
  assign state_dbg = state;

  assign skp_wrap = (skp_cnt == SKP_CNT_W'(SKP_INTERVAL - 1));

  // State register with the symbol chosen for the state being entered.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= S_IDLE;
      skp_idx   <= 2'd0;
      data_out  <= SYM_IDL;
      valid_out <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      state     <= next_state;
      skp_idx   <= next_skp_idx;
      data_out  <= next_data;
      valid_out <= next_valid;
      err_abort <= next_err;
    end
  end

  // Pending SKP is only honoured at packet boundaries (exit of IDLE/ENDS/ABRT/SKPS).
  always_comb begin
    exit_state = S_IDLE;
    if (skp_pend)       exit_state = S_SKPC;
    else if (req_valid) exit_state = S_STP;
  end

  always_comb begin
    next_state   = state;
    next_skp_idx = skp_idx;
    case (state)
      S_IDLE: next_state = exit_state;
      S_STP, S_DATA: begin
        if (!req_valid)    next_state = S_ABRT;
        else if (req_last) next_state = S_LAST;
        else               next_state = S_DATA;
      end
      S_LAST: next_state = S_ENDS;
      S_ENDS, S_ABRT: next_state = exit_state;
      S_SKPC: begin
        next_state   = S_SKPS;
        next_skp_idx = 2'd1;
      end
      S_SKPS: begin
        if (skp_idx < 2'(NUM_SKP)) begin
          next_state   = S_SKPS;
          next_skp_idx = skp_idx + 2'd1;
        end else begin
          next_state = exit_state;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    next_data  = SYM_IDL;
    next_valid = 1'b0;
    next_err   = 1'b0;
    case (next_state)
      S_STP:  next_data = SYM_STP;
      S_DATA, S_LAST: begin
        next_data  = req_data;
        next_valid = 1'b1;
      end
      S_ENDS: next_data = SYM_END;
      S_ABRT: begin
        next_data = SYM_EDB;
        next_err  = 1'b1;
      end
      S_SKPC: next_data = SYM_COM;
      S_SKPS: next_data = SYM_SKP;
      default: next_data = SYM_IDL;
    endcase
  end

  // A wrap on the same cycle as SKPC entry keeps the request set.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      skp_cnt  <= '0;
      skp_pend <= 1'b0;
    end else begin
      skp_cnt <= skp_wrap ? '0 : skp_cnt + 1'b1;
      if (skp_wrap)                  skp_pend <= 1'b1;
      else if (next_state == S_SKPC) skp_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_symbol_sequencer.sv
// Scoreboard bench for symbol_sequencer: expected wire symbols {err_abort, valid_out, data_out}
// are queued per scenario and compared one per cycle on the falling edge.
module tb_symbol_sequencer;

  localparam int W = 10;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_last = 1'b0;

  logic       rdy64, v64, err64, rdy8, v8, err8;
  logic [7:0] d64, d8;
  logic [2:0] st64, st8;

  logic [W-1:0] exp_q[$];
  logic [8:0]   tx_q[$];
  logic         sel8 = 1'b0;
  logic         pend_acc = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  symbol_sequencer #(.SKP_INTERVAL(64), .SKP_CNT_W(16), .NUM_SKP(3)) dut64 (
    .clk(clk), .reset_L(reset_L), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy64), .valid_out(v64), .data_out(d64),
    .err_abort(err64), .state_dbg(st64)
  );

  symbol_sequencer #(.SKP_INTERVAL(8), .SKP_CNT_W(16), .NUM_SKP(3)) dut8 (
    .clk(clk), .reset_L(reset_L), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy8), .valid_out(v8), .data_out(d8),
    .err_abort(err8), .state_dbg(st8)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    #1;
    reset_L = 1'b0;
    tx_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  // Requester driver: changes inputs only on the falling edge, popping a byte once accepted.
  always @(negedge clk) begin
    if (pend_acc && tx_q.size() > 0) void'(tx_q.pop_front());
    if (tx_q.size() > 0) begin
      req_valid = 1'b1;
      {req_last, req_data} = tx_q[0];
    end else begin
      req_valid = 1'b0;
      req_last  = 1'b0;
      req_data  = 8'h00;
    end
    pend_acc = req_valid && (sel8 ? rdy8 : rdy64);
  end

  function automatic logic [W-1:0] ctl(input logic [7:0] s);
    return {2'b00, s};
  endfunction

  function automatic logic [W-1:0] dat(input logic [7:0] b);
    return {2'b01, b};
  endfunction

  function automatic logic [8:0] byte_tx(input logic [7:0] b, input logic last);
    return {last, b};
  endfunction

  task automatic test_reset();
    reset_L = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({err64, v64, d64} !== ctl(8'h7c)) begin
      n_fail++;
      $display("FAIL reset_out64: got %h expected %h", {err64, v64, d64}, ctl(8'h7c));
    end
    n_checks++;
    if ({err8, v8, d8} !== ctl(8'h7c)) begin
      n_fail++;
      $display("FAIL reset_out8: got %h expected %h", {err8, v8, d8}, ctl(8'h7c));
    end
    n_checks++;
    if ({rdy64, rdy8} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 00", {rdy64, rdy8});
    end
  endtask

  task automatic test_idle_skp();
    logic [W-1:0] e, g;
    sel8 = 1'b0;
    apply_reset();
    repeat (64) exp_q.push_back(ctl(8'h7c));
    exp_q.push_back(ctl(8'hbc));
    repeat (3) exp_q.push_back(ctl(8'h1c));
    exp_q.push_back(ctl(8'h7c));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = {err64, v64, d64};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL idle_skp[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_single_packet();
    logic [W-1:0] e, g;
    int rdy_cnt;
    sel8 = 1'b0;
    apply_reset();
    rdy_cnt = 0;
    tx_q.push_back(byte_tx(8'h11, 1'b0));
    tx_q.push_back(byte_tx(8'h22, 1'b0));
    tx_q.push_back(byte_tx(8'h33, 1'b1));
    exp_q.push_back(ctl(8'h7c));
    exp_q.push_back(ctl(8'hfb));
    exp_q.push_back(dat(8'h11));
    exp_q.push_back(dat(8'h22));
    exp_q.push_back(dat(8'h33));
    exp_q.push_back(ctl(8'hfd));
    exp_q.push_back(ctl(8'h7c));
    exp_q.push_back(ctl(8'h7c));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (rdy64) rdy_cnt++;
      e = exp_q.pop_front();
      g = {err64, v64, d64};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL packet[%0d]: got %h expected %h", i, g, e);
      end
    end
    n_checks++;
    if (rdy_cnt != 3) begin
      n_fail++;
      $display("FAIL ready_cycles: got %0d expected 3", rdy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, g;
    sel8 = 1'b0;
    apply_reset();
    tx_q.push_back(byte_tx(8'haa, 1'b0));
    tx_q.push_back(byte_tx(8'hbb, 1'b1));
    tx_q.push_back(byte_tx(8'hcc, 1'b0));
    tx_q.push_back(byte_tx(8'hdd, 1'b1));
    exp_q.push_back(ctl(8'h7c));
    exp_q.push_back(ctl(8'hfb));
    exp_q.push_back(dat(8'haa));
    exp_q.push_back(dat(8'hbb));
    exp_q.push_back(ctl(8'hfd));
    exp_q.push_back(ctl(8'hfb));
    exp_q.push_back(dat(8'hcc));
    exp_q.push_back(dat(8'hdd));
    exp_q.push_back(ctl(8'hfd));
    exp_q.push_back(ctl(8'h7c));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = {err64, v64, d64};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] e, g;
    sel8 = 1'b0;
    apply_reset();
    tx_q.push_back(byte_tx(8'h40, 1'b0));
    tx_q.push_back(byte_tx(8'h41, 1'b0));
    exp_q.push_back(ctl(8'h7c));
    exp_q.push_back(ctl(8'hfb));
    exp_q.push_back(dat(8'h40));
    exp_q.push_back(dat(8'h41));
    exp_q.push_back({2'b10, 8'hfe});
    exp_q.push_back(ctl(8'h7c));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = {err64, v64, d64};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL abort[%0d]: got %h expected %h", i, g, e);
      end
    end
    #1;
    tx_q.push_back(byte_tx(8'h55, 1'b1));
    exp_q.push_back(ctl(8'h7c));
    exp_q.push_back(ctl(8'hfb));
    exp_q.push_back(dat(8'h55));
    exp_q.push_back(ctl(8'hfd));
    exp_q.push_back(ctl(8'h7c));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = {err64, v64, d64};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL restart[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_skp_deferred();
    logic [W-1:0] e, g;
    sel8 = 1'b1;
    apply_reset();
    repeat (8) exp_q.push_back(ctl(8'h7c));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = {err8, v8, d8};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL skp_pre[%0d]: got %h expected %h", i, g, e);
      end
    end
    #1;
    for (int b = 0; b < 10; b++) tx_q.push_back(byte_tx(8'ha0 + 8'(b), b == 9));
    tx_q.push_back(byte_tx(8'h77, 1'b1));
    exp_q.push_back(ctl(8'hbc));
    repeat (3) exp_q.push_back(ctl(8'h1c));
    exp_q.push_back(ctl(8'hfb));
    for (int b = 0; b < 10; b++) exp_q.push_back(dat(8'ha0 + 8'(b)));
    exp_q.push_back(ctl(8'hfd));
    exp_q.push_back(ctl(8'hbc));
    repeat (3) exp_q.push_back(ctl(8'h1c));
    exp_q.push_back(ctl(8'hfb));
    exp_q.push_back(dat(8'h77));
    exp_q.push_back(ctl(8'hfd));
    exp_q.push_back(ctl(8'h7c));
    exp_q.push_back(ctl(8'hbc));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = {err8, v8, d8};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL skp_wrap[%0d]: got %h expected %h", i, g, e);
      end
    end
    sel8 = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    logic [W-1:0] e, g;
    sel8 = 1'b0;
    apply_reset();
    for (int b = 0; b < 10; b++) tx_q.push_back(byte_tx(8'h60 + 8'(b), b == 9));
    exp_q.push_back(ctl(8'h7c));
    exp_q.push_back(ctl(8'hfb));
    exp_q.push_back(dat(8'h60));
    exp_q.push_back(dat(8'h61));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = {err64, v64, d64};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL pre_reset[%0d]: got %h expected %h", i, g, e);
      end
    end
    #3;
    reset_L = 1'b0;
    tx_q.delete();
    #1;
    n_checks++;
    if ({err64, v64, d64, rdy64} !== {ctl(8'h7c), 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", {err64, v64, d64, rdy64}, {ctl(8'h7c), 1'b0});
    end
    @(negedge clk);
    #1;
    reset_L = 1'b1;
    repeat (64) exp_q.push_back(ctl(8'h7c));
    exp_q.push_back(ctl(8'hbc));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = {err64, v64, d64};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_skp();
    test_single_packet();
    test_back_to_back();
    test_abort();
    test_skp_deferred();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
